// File: rtl/dma16.sv
// Single-channel block-copy DMA engine that borrows the CPU16 memory bus.
// Stalls the CPU via hold, copies count words src->dst, then hands the bus back.
module dma16 #(
    parameter logic RAM_WAIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] count,
    output logic        dma_busy,
    output logic        done,
    output logic        hold,
    input  logic        cpu_busy,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_data_out,
    input  logic        cpu_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data_out,
    output logic        mem_write,
    input  logic [15:0] mem_data_in
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        RWAIT,
        LATCH,
        WR,
        FIN
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] s_reg, s_next;
    logic [15:0] d_reg, d_next;
    logic [15:0] n_reg, n_next;
    logic [15:0] buf_reg, buf_next;
    logic        grant_reg, grant_next;
    logic [15:0] dma_address;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            s_reg     <= 16'd0;
            d_reg     <= 16'd0;
            n_reg     <= 16'd0;
            buf_reg   <= 16'd0;
            grant_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            d_reg     <= d_next;
            n_reg     <= n_next;
            buf_reg   <= buf_next;
            grant_reg <= grant_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        d_next     = d_reg;
        n_next     = n_reg;
        buf_next   = buf_reg;
        grant_next = grant_reg;
        case (state_reg)
            IDLE: begin
                // A zero-length request completes without ever stalling the CPU.
                if (start) begin
                    if (count != 16'd0) begin
                        s_next     = src;
                        d_next     = dst;
                        n_next     = count;
                        state_next = REQ;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            REQ: begin
                if (cpu_busy) begin
                    grant_next = 1'b1;
                    state_next = RD;
                end
            end
            RD:    state_next = RAM_WAIT ? RWAIT : LATCH;
            RWAIT: state_next = LATCH;
            LATCH: begin
                buf_next   = mem_data_in;
                s_next     = s_reg + 16'd1;
                state_next = WR;
            end
            WR: begin
                d_next = d_reg + 16'd1;
                n_next = n_reg - 16'd1;
                if (n_reg == 16'd1) begin
                    grant_next = 1'b0;
                    state_next = FIN;
                end else begin
                    state_next = RD;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode straight from registered state so an async reset drops them at once.
    assign hold     = (state_reg == REQ) || (state_reg == RD) || (state_reg == RWAIT) ||
                      (state_reg == LATCH) || (state_reg == WR);
    assign dma_busy = (state_reg != IDLE);
    assign done     = (state_reg == FIN);

    assign dma_address  = (state_reg == WR) ? d_reg : s_reg;
    assign mem_address  = grant_reg ? dma_address : cpu_address;
    assign mem_data_out = grant_reg ? buf_reg : cpu_data_out;
    assign mem_write    = grant_reg ? (state_reg == WR) : cpu_write;

endmodule

// File: tb/tb_dma16.sv
// Directed self-checking bench for dma16: behavioural RAM on the shared bus,
// CPU bus driven by the bench, cpu_busy derived from hold with optional delay.
module tb_dma16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] src, dst, count;
    logic        dma_busy, done, hold, cpu_busy;
    logic [15:0] cpu_address, cpu_data_out;
    logic        cpu_write;
    logic [15:0] mem_address, mem_data_out, mem_data_in;
    logic        mem_write;

    logic [15:0] ram [0:65535];
    logic [7:0]  hold_hist = 8'd0;
    logic [2:0]  busy_delay;

    int n_checks = 0;
    int n_fail   = 0;
    int dma_wr_cnt = 0;
    int done_cnt   = 0;
    int hold_cnt   = 0;
    int early_cnt  = 0;

    dma16 #(.RAM_WAIT(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src          (src),
        .dst          (dst),
        .count        (count),
        .dma_busy     (dma_busy),
        .done         (done),
        .hold         (hold),
        .cpu_busy     (cpu_busy),
        .cpu_address  (cpu_address),
        .cpu_data_out (cpu_data_out),
        .cpu_write    (cpu_write),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM on the shared bus.
    always @(posedge clk) begin
        if (mem_write) ram[mem_address] <= mem_data_out;
        mem_data_in <= ram[mem_address];
    end

    assign cpu_busy = (busy_delay == 3'd0) ? hold : hold_hist[busy_delay - 3'd1];

    always @(posedge clk) begin
        hold_hist <= {hold_hist[6:0], hold};
        if (mem_write && dma_busy) dma_wr_cnt <= dma_wr_cnt + 1;
        if (mem_write && dma_busy && !cpu_busy) early_cnt <= early_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (hold) hold_cnt <= hold_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        cpu_address  = a;
        cpu_data_out = v;
        cpu_write    = 1'b1;
        @(negedge clk);
        cpu_write    = 1'b0;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [15:0] v);
        @(negedge clk);
        cpu_address = a;
        @(negedge clk);
        v = mem_data_in;
    endtask

    // Leaves the caller at the negedge after the accepting edge (cycle 1).
    task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
        @(negedge clk);
        start = 1'b1;
        src   = s;
        dst   = d;
        count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] v;
        cpu_rd(a, v);
        check(tag, v, exp);
    endtask

    initial begin
        int k, w0, d0, h0, e0, seen;

        reset = 1'b0;
        start = 1'b0;
        src = 16'd0; dst = 16'd0; count = 16'd0;
        cpu_address = 16'h1234; cpu_data_out = 16'h5678; cpu_write = 1'b0;
        busy_delay = 3'd0;
        repeat (2) @(negedge clk);

        // Reset state: idle, bus passes the CPU through.
        check("reset_hold", {15'd0, hold}, 16'd0);
        check("reset_busy", {15'd0, dma_busy}, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_addr_pass", mem_address, 16'h1234);
        check("reset_dout_pass", mem_data_out, 16'h5678);
        check("reset_wr_pass", {15'd0, mem_write}, 16'd0);
        @(negedge clk);
        reset = 1'b1;

        cpu_wr(16'h0100, 16'h1111);
        cpu_wr(16'h0101, 16'h2222);
        cpu_wr(16'h0102, 16'h3333);
        cpu_wr(16'h0103, 16'h4444);
        cpu_wr(16'hFFFF, 16'hAAAA);
        cpu_wr(16'h0000, 16'h5555);
        cpu_wr(16'h0400, 16'hBEEF);
        cpu_wr(16'h0501, 16'hBEEF);

        // Basic copy of four words.
        w0 = dma_wr_cnt; d0 = done_cnt;
        do_start(16'h0100, 16'h0200, 16'd4);
        check("basic_hold_c1", {15'd0, hold}, 16'd1);
        check("basic_busy_c1", {15'd0, dma_busy}, 16'd1);
        wait_done(1, k);
        check("basic_latency", 16'(k), 16'd18);
        check("basic_hold_at_done", {15'd0, hold}, 16'd0);
        check("basic_busy_at_done", {15'd0, dma_busy}, 16'd1);
        @(negedge clk);
        check("basic_busy_after", {15'd0, dma_busy}, 16'd0);
        check("basic_writes", 16'(dma_wr_cnt - w0), 16'd4);
        check("basic_dones", 16'(done_cnt - d0), 16'd1);
        read_check("basic_w0", 16'h0200, 16'h1111);
        read_check("basic_w1", 16'h0201, 16'h2222);
        read_check("basic_w2", 16'h0202, 16'h3333);
        read_check("basic_w3", 16'h0203, 16'h4444);

        // Zero-length request.
        w0 = dma_wr_cnt; d0 = done_cnt; h0 = hold_cnt;
        do_start(16'h0300, 16'h0200, 16'd0);
        @(negedge clk);
        check("zero_dones", 16'(done_cnt - d0), 16'd1);
        check("zero_hold", 16'(hold_cnt - h0), 16'd0);
        check("zero_writes", 16'(dma_wr_cnt - w0), 16'd0);
        read_check("zero_mem", 16'h0200, 16'h1111);

        // CPU acknowledges 5 cycles after hold.
        busy_delay = 3'd5;
        cpu_address = 16'h4321;
        e0 = early_cnt;
        do_start(16'h0100, 16'h0700, 16'd2);
        check("hs_bus_pass", mem_address, 16'h4321);
        wait_done(1, k);
        check("hs_latency", 16'(k), 16'd15);
        check("hs_early_writes", 16'(early_cnt - e0), 16'd0);
        read_check("hs_w0", 16'h0700, 16'h1111);
        read_check("hs_w1", 16'h0701, 16'h2222);
        repeat (8) @(negedge clk);
        busy_delay = 3'd0;

        // Second start during a copy must be ignored.
        w0 = dma_wr_cnt; d0 = done_cnt;
        do_start(16'h0100, 16'h0300, 16'd4);
        repeat (4) @(negedge clk);
        start = 1'b1; src = 16'h0200; dst = 16'h0400; count = 16'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, k);
        check("rs_latency", 16'(k), 16'd18);
        @(negedge clk);
        check("rs_dones", 16'(done_cnt - d0), 16'd1);
        check("rs_writes", 16'(dma_wr_cnt - w0), 16'd4);
        read_check("rs_w0", 16'h0300, 16'h1111);
        read_check("rs_w3", 16'h0303, 16'h4444);
        read_check("rs_untouched", 16'h0400, 16'hBEEF);

        // Source pointer wraps from FFFF to 0000.
        do_start(16'hFFFF, 16'h0010, 16'd2);
        wait_done(1, k);
        check("wrap_latency", 16'(k), 16'd10);
        read_check("wrap_w0", 16'h0010, 16'hAAAA);
        read_check("wrap_w1", 16'h0011, 16'h5555);

        // Reset during the second WR cycle.
        do_start(16'h0100, 16'h0500, 16'd4);
        seen = 0; k = 1;
        while (seen < 2 && k < 40) begin
            @(negedge clk);
            k++;
            if (mem_write === 1'b1) seen++;
        end
        check("rst_second_wr_cycle", 16'(k), 16'd9);
        reset = 1'b0;
        #1;
        check("rst_mem_write", {15'd0, mem_write}, 16'd0);
        check("rst_hold", {15'd0, hold}, 16'd0);
        check("rst_busy", {15'd0, dma_busy}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_idle_busy", {15'd0, dma_busy}, 16'd0);
        read_check("rst_partial_w0", 16'h0500, 16'h1111);
        read_check("rst_partial_w1", 16'h0501, 16'hBEEF);
        do_start(16'h0100, 16'h0600, 16'd4);
        wait_done(1, k);
        check("post_rst_latency", 16'(k), 16'd18);
        read_check("post_rst_w0", 16'h0600, 16'h1111);
        read_check("post_rst_w3", 16'h0603, 16'h4444);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
